mem_access_ctrl: RTL

CPU-side initiator for the 512 x 32 word memory subsystem. It owns the MAR and MDR, accepts single or burst read/write requests from the datapath control unit over a req/busy/done handshake, and drives the memory's address, write-data and write-enable pins. The memory has a combinational read path and a synchronous write on the rising clock edge. Bursts of up to four consecutive words are supported, with address wrap-around.

---
 rtl/mem_ctrl_pkg.sv | 33 +++
 rtl/mem_access_ctrl_if.sv | 39 +++
 rtl/mem_addr_counter.sv | 48 ++++
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
// State encoding, memory geometry and the burst-length clamp.
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;
  localparam int MAX_BURST  = 4;
  localparam int LEN_W      = 3;
  localparam int BUS_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  // Out-of-range lengths are folded into 1..mx.
  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] l,
    input logic [LEN_W-1:0] mx
  );
    logic [LEN_W-1:0] r;
    r = l;
    if (l == '0) begin
      r = LEN_W'(1);
    end else if (l > mx) begin
      r = mx;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-pin bundle of the access controller.
// slave = controller side, master = control unit plus memory side.
interface mem_access_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  logic                  req;
  logic                  we;
  logic [BUS_ADDR_W-1:0] addr_in;
  logic [LEN_W-1:0]      len;
  logic [DATA_W-1:0]     wdata;
  logic                  busy;
  logic                  done;
  logic                  rvalid;
  logic                  wnext;
  logic [DATA_W-1:0]     rdata;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_din;
  logic                  mem_write;
  logic [DATA_W-1:0]     mem_dout;

  modport slave (
    input  req, we, addr_in, len, wdata,
    input  mem_dout,
    output busy, done, rvalid, wnext, rdata,
    output mem_addr, mem_din, mem_write
  );

  modport master (
    output req, we, addr_in, len, wdata,
    output mem_dout,
    input  busy, done, rvalid, wnext, rdata,
    input  mem_addr, mem_din, mem_write
  );

endinterface

// File: rtl/mem_addr_counter.sv
// MAR with load/increment (wraps at 2^ADDR_W) and beat down-counter.
// Ports: clk, reset, load_i/step_i, addr_i, len_i, max_i -> mar_o, last_o.
module mem_addr_counter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [LEN_W-1:0]  max_i,
  output logic [ADDR_W-1:0] mar_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [LEN_W-1:0]  beats_q, beats_d;

  always_comb begin
    mar_d   = mar_q;
    beats_d = beats_q;
    if (load_i) begin
      mar_d   = addr_i;
      beats_d = clamp_len(len_i, max_i);
    end else if (step_i) begin
      // natural overflow gives the 511 -> 0 wrap
      mar_d   = mar_q + ADDR_W'(1);
      beats_d = beats_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar_q   <= '0;
      beats_q <= '0;
    end else begin
      mar_q   <= mar_d;
      beats_q <= beats_d;
    end
  end

  assign mar_o  = mar_q;
  assign last_o = (beats_q <= LEN_W'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side memory initiator: MAR/MDR, single and burst read/write.
// Ports: clk, reset, bus (slave modport: req/busy/done + memory pins).
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int MAX_BURST = mem_ctrl_pkg::MAX_BURST
) (
  input  logic         clk,
  input  logic         reset,
  mem_access_ctrl_if.slave bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rvalid_q, rvalid_d;
  logic              wnext_q, wnext_d;
  logic              mwr_q, mwr_d;
  logic              load;
  logic              step;
  logic              last;
  logic [ADDR_W-1:0] mar;
  logic              unused_addr;

  assign unused_addr = ^bus.addr_in[BUS_ADDR_W-1:ADDR_W];

  mem_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .step_i (step),
    .addr_i (bus.addr_in[ADDR_W-1:0]),
    .len_i  (bus.len),
    .max_i  (MAX_LEN),
    .mar_o  (mar),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mdr_d   = mdr_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          load    = 1'b1;
          op_d    = bus.we;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (op_q) begin
          mdr_d = bus.wdata;
        end
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!op_q) begin
          mdr_d = bus.mem_dout;
        end
        if (last) begin
          state_d = DONE;
        end else begin
          step    = 1'b1;
          state_d = SETUP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs come straight from flops so mem_write cannot glitch;
    // async reset clears them in the same cycle.
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    wnext_d  = (state_d == SETUP) && op_d;
    mwr_d    = (state_d == ACCESS) && op_d;
    rvalid_d = (state_q == ACCESS) && !op_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      mdr_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      wnext_q  <= 1'b0;
      mwr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mdr_q    <= mdr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      wnext_q  <= wnext_d;
      mwr_q    <= mwr_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.wnext     = wnext_q;
  assign bus.rdata     = mdr_q;
  assign bus.mem_addr  = mar;
  assign bus.mem_din   = mdr_q;
  assign bus.mem_write = mwr_q;

endmodule
